// File: rtl/tag_alloc.sv
// Unique-tag allocator: hands out free slots with a tag distinct from all live tags.
// Slots are released by index; freeing a non-live slot raises a one-cycle error pulse.
module tag_alloc #(
  parameter int unsigned NSLOT = 8,
  parameter int unsigned TAG_W = 16,
  localparam int unsigned IDX_W = $clog2(NSLOT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  output logic [IDX_W-1:0]            gnt_idx,
  output logic [TAG_W-1:0]            gnt_tag,
  input  logic                        free_valid,
  input  logic [IDX_W-1:0]            free_idx,
  output logic [NSLOT-1:0]            vld,
  output logic [NSLOT-1:0][TAG_W-1:0] tag,
  output logic                        free_err
);

  logic [TAG_W-1:0]            next_tag;
  logic [TAG_W-1:0]            next_tag_nx;
  logic [NSLOT-1:0]            vld_nx;
  logic [NSLOT-1:0][TAG_W-1:0] tag_nx;
  logic                        free_err_nx;
  logic                        cand_hit;
  logic                        full;
  logic                        alloc;

  // Candidate collides with a live tag: this cycle is spent skipping it.
  always_comb begin
    cand_hit = 1'b0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      if (vld[i] && (tag[i] == next_tag)) cand_hit = 1'b1;
    end
  end

  // Lowest non-live slot; uses registered vld so a slot freed this cycle is not eligible.
  always_comb begin
    gnt_idx = '0;
    for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
      if (!vld[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign full      = &vld;
  assign req_ready = !full && !cand_hit;
  assign gnt_tag   = next_tag;
  assign alloc     = req_valid && req_ready;

  // Next-state: free and allocate never target the same slot (live vs non-live).
  always_comb begin
    vld_nx      = vld;
    tag_nx      = tag;
    next_tag_nx = next_tag;
    free_err_nx = 1'b0;
    if (free_valid) begin
      if (vld[free_idx]) vld_nx[free_idx] = 1'b0;
      else               free_err_nx      = 1'b1;
    end
    if (alloc) begin
      vld_nx[gnt_idx] = 1'b1;
      tag_nx[gnt_idx] = next_tag;
    end
    if (alloc || cand_hit) next_tag_nx = next_tag + TAG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld      <= '0;
      tag      <= '0;
      next_tag <= '0;
      free_err <= 1'b0;
    end else begin
      vld      <= vld_nx;
      tag      <= tag_nx;
      next_tag <= next_tag_nx;
      free_err <= free_err_nx;
    end
  end

endmodule

// File: doc/tag_alloc.md
TAG_ALLOC -- requirements
Module: tag_alloc

Interface
REQ-001 SHALL have parameter: NSLOT, 8, number of tag slots (power of 2, 2..8).
REQ-002 SHALL have parameter: TAG_W, 16, tag width in bits (>= log2(NSLOT)+1).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req_valid  input  1  requester wants a new tag.
REQ-006 SHALL have port: req_ready  output  1  allocation accepted this cycle.
REQ-007 SHALL have port: gnt_idx  output  log2(NSLOT)  slot granted; meaningful when req_valid && req_ready.
REQ-008 SHALL have port: gnt_tag  output  TAG_W  tag granted; meaningful when req_valid && req_ready.
REQ-009 SHALL have port: free_valid  input  1  release request.
REQ-010 SHALL have port: free_idx  input  log2(NSLOT)  slot to release.
REQ-011 SHALL have port: vld  output  NSLOT  per-slot live bit, registered.
REQ-012 SHALL have port: tag  output  NSLOT x TAG_W  per-slot tag (packed array), registered.
REQ-013 SHALL have port: free_err  output  1  one-cycle pulse, free of a non-live slot.

Function
REQ-014 SHALL hold next_tag, a TAG_W-bit candidate register.
REQ-015 SHALL compute cand_hit = OR over slots i of (vld[i] && tag[i] == next_tag).
REQ-016 SHALL compute full = &vld.
REQ-017 SHALL drive req_ready = !full && !cand_hit, combinationally from registered state only; it SHALL NOT depend on req_valid.
REQ-018 SHALL select gnt_idx as the lowest index with vld == 0, and SHALL drive gnt_tag = next_tag.
REQ-019 On req_valid && req_ready, SHALL set vld[gnt_idx] = 1 and tag[gnt_idx] = next_tag at the next edge.
REQ-020 SHALL increment next_tag by 1, modulo 2^TAG_W with wrap FFFF->0000 at TAG_W=16, on each accepted allocation.
REQ-021 When cand_hit = 1, SHALL increment next_tag by 1 regardless of req_valid; this is the skip state and req_ready = 0 for that cycle.
REQ-022 When neither cand_hit nor an accepted allocation occurs, SHALL hold next_tag.
REQ-023 On free_valid with vld[free_idx] = 1, SHALL clear vld[free_idx] at the next edge; tag[free_idx] holds its old value.
REQ-024 On free_valid with vld[free_idx] = 0, SHALL leave state unchanged and pulse free_err for exactly the next cycle.
REQ-025 On simultaneous alloc and free, both SHALL take effect.
REQ-026 A slot freed in cycle N SHALL NOT be granted in cycle N; it becomes eligible in cycle N+1.
REQ-027 On simultaneous alloc and free when full: req_ready = 0, and the free still completes.
REQ-028 Invariant: at every cycle, all live tags SHALL be pairwise distinct; for all i != j, vld[i] && vld[j] implies tag[i] != tag[j].
REQ-029 Invariant: gnt_tag SHALL differ from every live tag whenever req_ready = 1.
REQ-030 Allocation latency SHALL be 0 cycles, handshake and grant in the same cycle; the result SHALL be visible on vld/tag 1 cycle later.

Reset
REQ-031 While rst = 1 at posedge clk, SHALL set vld = 0, every tag entry = 0, next_tag = 0, and free_err = 0.
REQ-032 Reset SHALL override any allocation or free in the same cycle; a request pending during reset SHALL be dropped.
REQ-033 In the first cycle after reset, SHALL show req_ready = 1 and gnt_idx = 0.

Verification
REQ-034 Reset, then 8 back-to-back requests -> grants idx 0..7 with tags 0x0000..0x0007; vld = 0xFF; req_ready = 0 in the 9th cycle.
REQ-035 Full table, free_idx = 3 with req_valid = 1 in the same cycle -> no grant that cycle; next cycle grants idx 3 with tag 0x0008.
REQ-036 Slot 0 holds tag 0x0000 and is kept live; drive 65535 further alloc/free cycles on slot 1 until next_tag wraps to 0x0000 -> one cycle with req_ready = 0 (skip), then grant with tag 0x0001.
REQ-037 free_valid with free_idx = 5 while vld[5] = 0 -> free_err = 1 for exactly one cycle; vld unchanged.
REQ-038 Reset asserted mid-burst, with 4 slots live -> next cycle vld = 0 and next_tag = 0; first post-reset grant is idx 0, tag 0x0000.
REQ-039 The bench SHALL check the invariants of REQ-028 and REQ-029 every cycle under random req_valid, free_valid and free_idx, with rst held low after startup.
